// File: rtl/mc_pkg.sv
// Shared opcodes, state type and control-field encodings for the multicycle controller.
// The JAL state and opcode decode exist only when MC_CONTROL_JAL_EN is defined.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      RTEXE  = 4'd7,
      RTWB   = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      BEQ    = 4'd11,
      BNE    = 4'd12,
      JUMP   = 4'd13
`ifdef MC_CONTROL_JAL_EN
      , JAL  = 4'd14
`endif
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_REG     = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

   localparam logic [1:0] RDST_RT = 2'd0;
   localparam logic [1:0] RDST_RD = 2'd1;
   localparam logic [1:0] RDST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // States that hold a memory access open and are subject to the wait timer.
   function automatic logic is_wait_state(input state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller-to-datapath/memory bundle; the controller uses the slave modport.
interface mc_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_read;
   logic       mem_write;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic       pc_write_cond;
   logic       pc_write_ncond;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal;
   logic       bus_err;
   logic [3:0] state_o;

   modport slave (
      input  opcode, mem_ready,
      output mem_req, mem_read, mem_write, iord, ir_write, pc_write,
             pc_write_cond, pc_write_ncond, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, illegal, bus_err, state_o
   );

   modport master (
      output opcode, mem_ready,
      input  mem_req, mem_read, mem_write, iord, ir_write, pc_write,
             pc_write_cond, pc_write_ncond, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, illegal, bus_err, state_o
   );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts stalled memory cycles and flags a timeout; bus_err is sticky until reset.
module mc_wait_timer #(
   parameter int TIMEOUT = 15,
   parameter int WAIT_W  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   input  logic mem_ready,
   output logic timeout,
   output logic bus_err
);

   logic [WAIT_W-1:0] count;

   assign timeout = busy && !mem_ready && (count == WAIT_W'(TIMEOUT));

   // Any cycle that is not a stalled wait clears the count, so every access starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         bus_err <= 1'b0;
      end else begin
         if (busy && !mem_ready && !timeout)
            count <= count + WAIT_W'(1);
         else
            count <= '0;
         if (timeout)
            bus_err <= 1'b1;
      end
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with memory wait/timeout handling.
// Define MC_CONTROL_JAL_EN to add the JAL instruction.
module mc_control
   import mc_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int WAIT_W  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   mc_control_if.slave bus
);

   state_t state, state_next;
   logic   timeout, bus_err, legal_op;

   mc_wait_timer #(.TIMEOUT(TIMEOUT), .WAIT_W(WAIT_W)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .busy      (is_wait_state(state)),
      .mem_ready (bus.mem_ready),
      .timeout   (timeout),
      .bus_err   (bus_err)
   );

   always_comb begin
      legal_op = 1'b0;
      case (bus.opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: legal_op = 1'b1;
`ifdef MC_CONTROL_JAL_EN
         OP_JAL: legal_op = 1'b1;
`endif
         default: legal_op = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // A timed-out access falls back to FETCH; FETCH simply stays put and refetches.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   state_next = FETCH;
         FETCH:  if (bus.mem_ready) state_next = DECODE;
         DECODE: begin
            case (bus.opcode)
               OP_RTYPE:      state_next = RTEXE;
               OP_LW, OP_SW:  state_next = MEMADR;
               OP_BEQ:        state_next = BEQ;
               OP_BNE:        state_next = BNE;
               OP_ADDI:       state_next = ADDIEX;
               OP_J:          state_next = JUMP;
`ifdef MC_CONTROL_JAL_EN
               OP_JAL:        state_next = JAL;
`endif
               default:       state_next = FETCH;
            endcase
         end
         MEMADR: state_next = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  begin
            if (bus.mem_ready)  state_next = MEMWB;
            else if (timeout)   state_next = FETCH;
         end
         MEMWR:  if (bus.mem_ready || timeout) state_next = FETCH;
         ADDIEX: state_next = ADDIWB;
         RTEXE:  state_next = RTWB;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      bus.mem_req        = 1'b0;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      bus.iord           = 1'b0;
      bus.ir_write       = 1'b0;
      bus.pc_write       = 1'b0;
      bus.pc_write_cond  = 1'b0;
      bus.pc_write_ncond = 1'b0;
      bus.reg_dst        = RDST_RT;
      bus.mem_to_reg     = M2R_ALUOUT;
      bus.reg_write      = 1'b0;
      bus.alu_src_a      = 1'b0;
      bus.alu_src_b      = SRCB_REG;
      bus.alu_op         = ALU_ADD;
      bus.pc_source      = PCSRC_ALU;
      bus.illegal        = 1'b0;
      case (state)
         FETCH: begin
            bus.mem_req   = !timeout;
            bus.mem_read  = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         DECODE: begin
            bus.alu_src_b = SRCB_IMM_SL2;
            bus.illegal   = !legal_op;
         end
         MEMADR, ADDIEX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
         end
         MEMRD: begin
            bus.mem_req  = !timeout;
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
         end
         MEMWR: begin
            bus.mem_req   = !timeout;
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
         end
         MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = M2R_MDR;
         end
         RTEXE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_FUNCT;
         end
         RTWB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = RDST_RD;
         end
         ADDIWB: bus.reg_write = 1'b1;
         BEQ, BNE: begin
            bus.alu_src_a      = 1'b1;
            bus.alu_op         = ALU_SUB;
            bus.pc_source      = PCSRC_ALUOUT;
            bus.pc_write_cond  = (state == BEQ);
            bus.pc_write_ncond = (state == BNE);
         end
         JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PCSRC_JUMP;
         end
`ifdef MC_CONTROL_JAL_EN
         JAL: begin
            bus.pc_write   = 1'b1;
            bus.pc_source  = PCSRC_JUMP;
            bus.reg_write  = 1'b1;
            bus.reg_dst    = RDST_RA;
            bus.mem_to_reg = M2R_PC;
         end
`endif
         default: ;
      endcase
   end

   assign bus.bus_err = bus_err;
   assign bus.state_o = state;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed and randomized instruction streams
// checked cycle by cycle against an instruction-level model of the controller.
module tb_mc_control;
   import mc_pkg::*;

   localparam int TIMEOUT = 15;

   typedef struct packed {
      logic       mem_req, mem_read, mem_write, iord;
      logic       ir_write, pc_write, pc_write_cond, pc_write_ncond;
      logic [1:0] reg_dst, mem_to_reg;
      logic       reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       illegal;
   } ctrl_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] cur_op;
   logic       err_exp;
   int         vectors = 0;
   int         miscompares = 0;

   mc_control_if bus();

   mc_control #(.TIMEOUT(TIMEOUT), .WAIT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic ctrl_t obs_ctrl();
      return {bus.mem_req, bus.mem_read, bus.mem_write, bus.iord,
              bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_write_ncond,
              bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};
   endfunction

   // Control word each state must present, written from the state descriptions.
   function automatic ctrl_t spec_ctrl(input state_t s, input logic ready,
                                       input logic expired, input logic bad);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:  begin c.mem_req = !expired; c.mem_read = 1; c.alu_src_b = 2'd1;
                       c.ir_write = ready; c.pc_write = ready; end
         DECODE: begin c.alu_src_b = 2'd3; c.illegal = bad; end
         MEMADR, ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
         MEMRD:  begin c.mem_req = !expired; c.mem_read = 1; c.iord = 1; end
         MEMWR:  begin c.mem_req = !expired; c.mem_write = 1; c.iord = 1; end
         MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 2'd1; end
         RTEXE:  begin c.alu_src_a = 1; c.alu_op = 2'd2; end
         RTWB:   begin c.reg_write = 1; c.reg_dst = 2'd1; end
         ADDIWB: c.reg_write = 1;
         BEQ:    begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_source = 2'd1; c.pc_write_cond = 1; end
         BNE:    begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_source = 2'd1; c.pc_write_ncond = 1; end
         JUMP:   begin c.pc_write = 1; c.pc_source = 2'd2; end
`ifdef MC_CONTROL_JAL_EN
         JAL:    begin c.pc_write = 1; c.pc_source = 2'd2; c.reg_write = 1;
                       c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
`endif
         default: ;
      endcase
      return c;
   endfunction

   task automatic applyStimulus(input logic [5:0] op, input logic ready);
      bus.opcode    = op;
      bus.mem_ready = ready;
   endtask

   task automatic checkOutput(input string tag, input state_t s, input ctrl_t exp);
      ctrl_t obs;
      obs = obs_ctrl();
      vectors++;
      assert (bus.state_o === s) else begin
         miscompares++;
         $error("[TB] FAIL %s state_o: observed %0d expected %0d", tag, bus.state_o, s);
      end
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s ctrl: observed %h expected %h", tag, obs, exp);
      end
      vectors++;
      assert (bus.bus_err === err_exp) else begin
         miscompares++;
         $error("[TB] FAIL %s bus_err: observed %b expected %b", tag, bus.bus_err, err_exp);
      end
   endtask

   // One clock in state s: drive, sample at the falling edge, then advance.
   task automatic step(input state_t s, input logic ready, input logic expired, input logic bad);
      applyStimulus(cur_op, ready);
      @(negedge clk);
      checkOutput(s.name(), s, spec_ctrl(s, ready, expired, bad));
      @(posedge clk);
      #1;
      if (expired) err_exp = 1'b1;
   endtask

   task automatic plain(input state_t s);
      step(s, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   // Memory access: ready stays low for 'waits' cycles; the access aborts once TIMEOUT stalls pass.
   task automatic access(input state_t s, input int waits, output bit ok);
      logic r, ex;
      ok = 1'b0;
      for (int k = 0; k <= TIMEOUT; k++) begin
         r  = (k >= waits);
         ex = (k == TIMEOUT) && !r;
         step(s, r, ex, 1'b0);
         if (r) begin ok = 1'b1; return; end
         if (ex) return;
      end
   endtask

   task automatic runInstr(input logic [5:0] op, input int fw, input int dw);
      bit   ok;
      logic bad;
      cur_op = op;
      access(FETCH, fw, ok);
      if (!ok) return;
      bad = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                         6'b000101, 6'b001000, 6'b000010});
`ifdef MC_CONTROL_JAL_EN
      if (op == 6'b000011) bad = 1'b0;
`endif
      step(DECODE, 1'($urandom_range(0, 1)), 1'b0, bad);
      case (op)
         6'b000000: begin plain(RTEXE); plain(RTWB); end
         6'b001000: begin plain(ADDIEX); plain(ADDIWB); end
         6'b100011: begin plain(MEMADR); access(MEMRD, dw, ok); if (ok) plain(MEMWB); end
         6'b101011: begin plain(MEMADR); access(MEMWR, dw, ok); end
         6'b000100: plain(BEQ);
         6'b000101: plain(BNE);
         6'b000010: plain(JUMP);
`ifdef MC_CONTROL_JAL_EN
         6'b000011: plain(JAL);
`endif
         default: ;
      endcase
   endtask

   initial begin
      logic [5:0] pool [10];
      pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
               6'b001000, 6'b000010, 6'b000011, 6'b111111, 6'b010101};
      err_exp = 1'b0;
      cur_op  = 6'b100011;
      rst_n   = 1'b1;
      applyStimulus(6'b100011, 1'b1);
      #1 rst_n = 1'b0;
      #2 checkOutput("reset_hold", IDLE, '0);
      @(posedge clk); #1;
      checkOutput("reset_clocked", IDLE, '0);
      rst_n = 1'b1;
      plain(IDLE);

      runInstr(6'b100011, 0, 0);
      runInstr(6'b101011, 0, 3);
      runInstr(6'b000100, 0, 0);
      runInstr(6'b000101, 0, 0);
      runInstr(6'b000000, 1, 0);
      runInstr(6'b001000, 0, 0);
      runInstr(6'b000010, 2, 0);
      runInstr(6'b111111, 0, 0);
      runInstr(6'b000011, 0, 0);

      for (int i = 0; i < 40; i++) begin
         if (i % 4 == 3)
            runInstr(6'($urandom_range(0, 63)), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            runInstr(pool[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 4));
      end

      runInstr(6'b100011, TIMEOUT, TIMEOUT);
      runInstr(6'b101011, 0, TIMEOUT);
      runInstr(6'b000000, TIMEOUT + 1, 0);
      runInstr(6'b000000, 0, 0);
      runInstr(6'b100011, 0, TIMEOUT + 1);
      runInstr(6'b000100, 1, 0);

      cur_op = 6'b100011;
      begin
         bit ok;
         access(FETCH, 0, ok);
      end
      plain(DECODE);
      plain(MEMADR);
      applyStimulus(6'b100011, 1'b0);
      #2 rst_n = 1'b0;
      err_exp = 1'b0;
      #1 checkOutput("reset_mid_memrd", IDLE, '0);
      applyStimulus(6'b100011, 1'b1);
      @(posedge clk); #1;
      checkOutput("reset_mid_clocked", IDLE, '0);
      rst_n = 1'b1;
      plain(IDLE);
      runInstr(6'b000101, 0, 0);
      runInstr(6'b100011, 2, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles on one memory access before bus error.
REQ-002 The module SHALL have parameter WAIT_W, default 4, meaning the wait-counter width, with TIMEOUT < 2**WAIT_W.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port opcode, input, 6 bits: instruction register bits [31:26].
REQ-006 The module SHALL have port mem_ready, input, 1 bit: memory completes the current access.
REQ-007 The module SHALL have port mem_req, output, 1 bit: memory access requested.
REQ-008 The module SHALL have ports mem_read and mem_write, output, 1 bit each.
REQ-009 The module SHALL have ports iord, ir_write, pc_write, pc_write_cond and pc_write_ncond, output, 1 bit each.
REQ-010 The module SHALL have ports reg_dst and mem_to_reg, output, 2 bits each: 0=rt/ALUOut, 1=rd/MDR, 2=$31/PC.
REQ-011 The module SHALL have ports reg_write and alu_src_a, output, 1 bit each.
REQ-012 The module SHALL have port alu_src_b, output, 2 bits: 0=B, 1=4, 2=signext, 3=signext<<2.
REQ-013 The module SHALL have port alu_op, output, 2 bits: 00=add, 01=sub, 10=funct.
REQ-014 The module SHALL have port pc_source, output, 2 bits: 0=ALU, 1=ALUOut, 2=jump target.
REQ-015 The module SHALL have ports illegal and bus_err, output, 1 bit each.
REQ-016 The module SHALL have port state_o, output, 4 bits: current state encoding, for debug.

Function
REQ-017 The FSM SHALL implement states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEX, ADDIWB, BEQ, BNE, JUMP, and JAL (JAL only when macro enabled).
REQ-018 IDLE SHALL drive all outputs 0 and SHALL go to FETCH on the next cycle.
REQ-019 FETCH SHALL assert mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00 and pc_source=0.
REQ-020 In FETCH, ir_write and pc_write SHALL be asserted only in the cycle in which mem_ready=1 (Mealy); the FSM SHALL advance to DECODE on that edge.
REQ-021 DECODE SHALL assert alu_src_a=0, alu_src_b=3, alu_op=00, and branch on opcode.
REQ-022 DECODE SHALL dispatch as follows: 000000 to RTEXE; 100011/101011 to MEMADR; 000100 to BEQ; 000101 to BNE; 001000 to ADDIEX; 000010 to JUMP; 000011 to JAL when enabled.
REQ-023 For any other opcode in DECODE, illegal SHALL pulse for 1 cycle and the FSM SHALL go to FETCH with no register or memory write.
REQ-024 MEMADR and ADDIEX SHALL assert alu_src_a=1, alu_src_b=2, alu_op=00; MEMADR SHALL go to MEMRD for lw or MEMWR for sw.
REQ-025 MEMRD SHALL assert mem_req, mem_read and iord=1, and SHALL wait for mem_ready before going to MEMWB.
REQ-026 MEMWR SHALL assert mem_req, mem_write and iord=1, and SHALL wait for mem_ready before going to FETCH.
REQ-027 MEMWB SHALL assert reg_write, reg_dst=0 and mem_to_reg=1.
REQ-028 RTEXE SHALL assert alu_src_a=1, alu_src_b=0, alu_op=10.
REQ-029 RTWB SHALL assert reg_write, reg_dst=1 and mem_to_reg=0.
REQ-030 ADDIWB SHALL assert reg_write, reg_dst=0 and mem_to_reg=0.
REQ-031 BEQ and BNE SHALL assert alu_src_a=1, alu_src_b=0, alu_op=01 and pc_source=1; BEQ SHALL assert pc_write_cond and BNE SHALL assert pc_write_ncond.
REQ-032 JUMP SHALL assert pc_write with pc_source=2.
REQ-033 After MEMWB, RTWB, ADDIWB, BEQ, BNE, JUMP or JAL the FSM SHALL return to FETCH.
REQ-034 Instruction latencies in cycles with zero wait SHALL be: R 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.
REQ-035 The wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and SHALL increment each cycle that mem_req=1 and mem_ready=0.
REQ-036 When the wait counter reaches TIMEOUT with mem_ready=0, bus_err SHALL set (sticky until reset), mem_req SHALL drop and the FSM SHALL go to FETCH with no writes.
REQ-037 If mem_ready=1 in the same cycle the counter reaches TIMEOUT, the access SHALL complete normally and bus_err SHALL NOT set.
REQ-038 mem_ready outside a wait state SHALL be ignored.

Reset
REQ-039 rst_n=0 SHALL force state IDLE, wait counter 0 and bus_err 0 immediately, regardless of the clock.
REQ-040 While rst_n=0 all outputs SHALL be 0, including mid-access; an aborted access SHALL NOT produce ir_write, pc_write or reg_write.
REQ-041 After rst_n rises, the FSM SHALL spend one cycle in IDLE, then go to FETCH.

Configuration
REQ-042 With MC_CONTROL_JAL_EN defined, opcode 000011 SHALL go to JAL, which asserts pc_write, pc_source=2, reg_write, reg_dst=2 and mem_to_reg=2, then returns to FETCH (3 cycles).
REQ-043 Without MC_CONTROL_JAL_EN, opcode 000011 SHALL be illegal and the JAL state SHALL not exist.

Structure
REQ-044 Package mc_pkg SHALL hold the opcode constants, the state enum typedef (4 bits) and the alu_op, alu_src_b, reg_dst, mem_to_reg and pc_source encodings.
REQ-045 The wait counter/timeout logic SHALL be one sub-module, mc_wait_timer.

Verification
REQ-046 Reset, then lw with mem_ready=1 in both access states -> state sequence IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1 only in MEMWB with mem_to_reg=1.
REQ-047 sw with mem_ready held low 3 cycles in MEMWR -> mem_write held 4 cycles, no bus_err, then FETCH.
REQ-048 FETCH with mem_ready never high, TIMEOUT=15 -> bus_err=1 after 15 wait cycles, FSM back in FETCH; bus_err stays 1 until rst_n=0.
REQ-049 Opcode 111111 in DECODE -> illegal=1 for one cycle, no writes, next state FETCH; opcode 000011 behaves the same without MC_CONTROL_JAL_EN, and gives reg_dst=2 with it.
REQ-050 Asserting rst_n=0 mid-MEMRD -> all outputs 0 immediately, no reg_write, IDLE for one cycle after release.
REQ-051 beq then bne back to back -> 3 cycles each, pc_write_cond only in BEQ, pc_write_ncond only in BNE, alu_op=01 in both.
